instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream instruction sequencer for the simple 9-bit processor. It replaces the free-running 5-bit address counter and ROM pair.
- Holds a loadable 32x9 program store.
- Presents each instruction word on Din and pulses run for one cycle.
- Supplies the immediate word for mvi on the following cycle.
- Advances only after the control unit reports done.
Runs on the processor clock.

Parameters:
ADDR_W, 5, program-counter / store address width
DATA_W, 9, instruction word width (III XXX YYY)
PROG_LEN, 32, number of words executed before end-of-program
WRAP, 0, 1 = wrap pc to 0 at end-of-program, 0 = halt

Ports:
clk  in  1  processor clock
rst  in  1  asynchronous, active-low reset
start  in  1  level; begin execution from address 0 when idle or halted
prog_we  in  1  program-store write enable (honoured only when busy=0)
prog_addr  in  ADDR_W  program-store write address
prog_data  in  DATA_W  program-store write data
done  in  1  completion pulse from control unit FSM
run  out  1  one-cycle instruction-valid pulse to control unit
Din  out  DATA_W  instruction/immediate word to control unit and datapath
ADDRESS  out  ADDR_W  current program counter
busy  out  1  high in any state other than IDLE and HALT
halted  out  1  high in HALT
fetch_state  out  3  encoded current state (debug)

Behaviour:
- States:
  - IDLE=0
  - FETCH=1
  - ISSUE=2
  - IMM=3
  - WAIT=4
  - HALT=5
  - PAUSE=6 (optional feature only)
- Reset (rst=0, asynchronous): state=IDLE, pc=0, run=0, Din=0, busy=0, halted=0. Program-store contents are not cleared. Reset mid-instruction abandons it; no further run pulse.
- Program store: synchronous read, 1-cycle latency; Din is the registered read data.
  - Write wins over read only in IDLE/HALT.
  - prog_we while busy=1 is ignored.
- IDLE/HALT: start=1 -> pc=0, FETCH.
- FETCH: read address = pc; next cycle -> ISSUE.
- ISSUE:
  - Din = mem[pc]; run=1 for exactly this cycle.
  - Read address = pc+1, speculatively.
  - If Din[8:6]==3'b001 (mvi) -> IMM, else -> WAIT.
  - done in ISSUE is ignored.
- IMM: Din = mem[pc+1] (immediate) for exactly one cycle; run=0 -> WAIT.
  - done in IMM is accepted as completion; the transition is then as for WAIT.
- WAIT: hold Din; on done=1 compute pc_next = pc+2 (mvi) or pc+1 (other opcodes).
  - If pc_next >= PROG_LEN: WRAP=1 -> pc=0, FETCH; WRAP=0 -> HALT.
  - Otherwise pc=pc_next, FETCH.
- Arithmetic: pc_next is computed at ADDR_W+1 bits, so 31+1 and 31+2 are detected as end-of-program, not silently wrapped.
  - mvi at address PROG_LEN-1 reads immediate from address 0 (modular read) and then ends.
- start while busy=1 is ignored.
- Instruction issue period, non-mvi: FETCH, ISSUE, then WAIT for at least 1 cycle, so at least 3 cycles per instruction.
- ADDRESS always equals pc.
- fetch_state mirrors the state encoding above.

Optional Feature:
- Macro IFU_SINGLE_STEP_EN adds input step (1 bit).
- With the macro: after done is accepted in WAIT/IMM and the program is not ending, the FSM enters PAUSE (busy stays 1). A step=1 cycle moves it to FETCH. End-of-program still goes directly to HALT/wrap.
- Without the macro: no step port, no PAUSE state, and WAIT goes directly to FETCH.

Decomposition:
- Shared package sproc_pkg:
  - ADDR_W/DATA_W constants
  - opcode enum (MV=3'b000, MVI=3'b001, ADD=3'b010, SUB=3'b011)
  - fetch-state enum (3 bits)
  - function is_mvi(word)
- Control unit FSM and testbench import the same package.
- One sub-module: prog_mem (2^ADDR_W x DATA_W, one sync write port, one sync read port, no reset on array).

Test Plan:
1. Load mem[0]=9'h040 (mvi R0), mem[1]=9'h005, mem[2]=9'h080 (add R0,R0); PROG_LEN=3, start=1 -> run pulse with Din=9'h040, next cycle Din=9'h005; after done, run pulse with Din=9'h080, ADDRESS=2; after done, halted=1, busy=0.
2. Hold done=0 for 10 cycles in WAIT -> Din stable at 9'h080, run stays 0, ADDRESS unchanged; done=1 -> single advance.
3. PROG_LEN=32, WRAP=1, mem[31]=9'h000 (mv) -> after done, ADDRESS=0 and next run pulse Din=mem[0]; WRAP=0 -> halted=1.
4. Assert rst=0 during WAIT at pc=7 -> immediately run=0, Din=0, ADDRESS=0, state=IDLE; program contents intact on restart (mem[0] reissued).
5. prog_we=1 with prog_addr=2, prog_data=9'h0C0 while busy=1 -> mem[2] unchanged (still 9'h080 when issued); same write in HALT -> subsequent run issues 9'h0C0.
6. IFU_SINGLE_STEP_EN defined: after first done, fetch_state=6 and no run pulse for 5 cycles; step=1 -> FETCH, run pulse 2 cycles later.

Source files
------------

// File: rtl/sproc_pkg.sv
// sproc_pkg: shared constants, opcode encoding and fetch-state encoding for
// the simple 9-bit processor (fetch unit, control unit and benches).
package sproc_pkg;

    localparam int SPROC_ADDR_W = 5;
    localparam int SPROC_DATA_W = 9;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_e;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_FETCH = 3'd1,
        FS_ISSUE = 3'd2,
        FS_IMM   = 3'd3,
        FS_WAIT  = 3'd4,
        FS_HALT  = 3'd5,
        FS_PAUSE = 3'd6
    } fetch_state_e;

    // An instruction is III XXX YYY; mvi carries its immediate in the next word.
    function automatic logic is_mvi(input logic [SPROC_DATA_W-1:0] word);
        return word[SPROC_DATA_W-1 -: 3] == OP_MVI;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_prog_mem.sv
// prog_mem: program store with one synchronous write port and one
// synchronous read port. The array itself is never reset; only the read
// data register is, so the word presented downstream is 0 after reset.
module prog_mem
    import sproc_pkg::*;
#(
    parameter int ADDR_W = SPROC_ADDR_W,
    parameter int DATA_W = SPROC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] store [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Write port: contents survive reset so a loaded program can be rerun.
    always_ff @(posedge clk) begin
        if (we) begin
            store[waddr] <= wdata;
        end
    end

    // Read data only moves on an enabled read, otherwise the word is held.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = store[raddr];
        end
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequences instructions from the program store to the
// control unit. Each word is presented on Din with a one-cycle run pulse,
// the mvi immediate follows on the next cycle, and the pc only advances
// once the control unit reports done.
// Optional macro IFU_SINGLE_STEP_EN adds a step input and a PAUSE state
// between instructions.
module instr_fetch_unit
    import sproc_pkg::*;
#(
    parameter int ADDR_W   = SPROC_ADDR_W,
    parameter int DATA_W   = SPROC_DATA_W,
    parameter int PROG_LEN = 32,
    parameter int WRAP     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              done,
`ifdef IFU_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              run,
    output logic [DATA_W-1:0] Din,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        fetch_state
);

    // End-of-program compare is one bit wider than the pc so that 31+1 and
    // 31+2 are seen as past the end instead of wrapping to 0 and 1.
    localparam logic [ADDR_W:0] PROG_END = (ADDR_W + 1)'(PROG_LEN);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mvi_q, mvi_d;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic [ADDR_W:0]   pc_inc;
    logic              prog_end;

    // Loading is only allowed while the sequencer is parked.
    assign mem_we = prog_we & ~busy;

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Next state, next pc and store read control for the fetch sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mvi_d    = mvi_q;
        rd_en    = 1'b0;
        rd_addr  = pc_q;
        pc_inc   = {1'b0, pc_q} + {{(ADDR_W - 1){1'b0}}, mvi_q, ~mvi_q};
        prog_end = (pc_inc >= PROG_END);

        case (state_q)
            FS_IDLE, FS_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FS_FETCH;
                end
            end
            FS_FETCH: begin
                rd_en   = 1'b1;
                state_d = FS_ISSUE;
            end
            FS_ISSUE: begin
                // The immediate read is only launched for mvi so that Din
                // keeps the instruction word for every other opcode.
                mvi_d   = is_mvi(rd_data);
                rd_addr = pc_q + ADDR_W'(1);
                rd_en   = is_mvi(rd_data);
                state_d = is_mvi(rd_data) ? FS_IMM : FS_WAIT;
            end
            FS_IMM, FS_WAIT: begin
                if (done) begin
                    if (prog_end) begin
                        if (WRAP != 0) begin
                            pc_d    = '0;
                            state_d = FS_FETCH;
                        end else begin
                            state_d = FS_HALT;
                        end
                    end else begin
                        pc_d    = pc_inc[ADDR_W-1:0];
`ifdef IFU_SINGLE_STEP_EN
                        state_d = FS_PAUSE;
`else
                        state_d = FS_FETCH;
`endif
                    end
                end else begin
                    state_d = FS_WAIT;
                end
            end
`ifdef IFU_SINGLE_STEP_EN
            FS_PAUSE: begin
                if (step) begin
                    state_d = FS_FETCH;
                end
            end
`endif
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FS_IDLE;
            pc_q    <= '0;
            mvi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mvi_q   <= mvi_d;
        end
    end

    assign run         = (state_q == FS_ISSUE);
    assign Din         = rd_data;
    assign ADDRESS     = pc_q;
    assign busy        = (state_q != FS_IDLE) && (state_q != FS_HALT);
    assign halted      = (state_q == FS_HALT);
    assign fetch_state = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: three fetch units (short halting program, 32-word
// wrapping program, 32-word halting program) driven with directed steps and
// random programs / done delays, checked against an instruction-level model
// of the program flow kept in model_mem.
module tb_instr_fetch_unit;
    import sproc_pkg::*;

`ifdef IFU_SINGLE_STEP_EN
    localparam logic [2:0] AFTER_DONE_STATE = FS_PAUSE;
`else
    localparam logic [2:0] AFTER_DONE_STATE = FS_FETCH;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] prog_we;
    logic [2:0] done;
    logic [4:0] prog_addr;
    logic [8:0] prog_data;
`ifdef IFU_SINGLE_STEP_EN
    logic [2:0] step;
`endif
    logic [2:0] run;
    logic [2:0] busy;
    logic [2:0] halted;
    logic [8:0] din [3];
    logic [4:0] address [3];
    logic [2:0] fstate [3];

    logic [8:0] model_mem [3][32];
    int assert_count;
    int fail_count;

    instr_fetch_unit #(.PROG_LEN(3), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .prog_we(prog_we[0]),
        .prog_addr(prog_addr), .prog_data(prog_data), .done(done[0]),
`ifdef IFU_SINGLE_STEP_EN
        .step(step[0]),
`endif
        .run(run[0]), .Din(din[0]), .ADDRESS(address[0]), .busy(busy[0]),
        .halted(halted[0]), .fetch_state(fstate[0])
    );

    instr_fetch_unit #(.PROG_LEN(32), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .prog_we(prog_we[1]),
        .prog_addr(prog_addr), .prog_data(prog_data), .done(done[1]),
`ifdef IFU_SINGLE_STEP_EN
        .step(step[1]),
`endif
        .run(run[1]), .Din(din[1]), .ADDRESS(address[1]), .busy(busy[1]),
        .halted(halted[1]), .fetch_state(fstate[1])
    );

    instr_fetch_unit #(.PROG_LEN(32), .WRAP(0)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .prog_we(prog_we[2]),
        .prog_addr(prog_addr), .prog_data(prog_data), .done(done[2]),
`ifdef IFU_SINGLE_STEP_EN
        .step(step[2]),
`endif
        .run(run[2]), .Din(din[2]), .ADDRESS(address[2]), .busy(busy[2]),
        .halted(halted[2]), .fetch_state(fstate[2])
    );

    // Free-running processor clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic st, input logic dn);
        start[d] = st;
        done[d]  = dn;
        tick();
        start[d] = 1'b0;
        done[d]  = 1'b0;
    endtask

    task automatic loadWord(input int d, input logic [4:0] a, input logic [8:0] v, input bit honoured);
        checkOutput("writeGateBusy", busy[d], !honoured);
        prog_addr   = a;
        prog_data   = v;
        prog_we[d]  = 1'b1;
        tick();
        prog_we[d]  = 1'b0;
        if (honoured) model_mem[d][a] = v;
    endtask

    task automatic loadRandomProgram(input int d);
        logic [8:0] w;
        for (int a = 0; a < 32; a++) begin
            w = 9'($urandom);
            w[8:6] = 3'($urandom_range(0, 3));
            loadWord(d, 5'(a), w, 1'b1);
        end
    endtask

    task automatic waitRun(input int d, input int max_cycles);
        int n = 0;
        while (run[d] !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput("runSeen", run[d], 1);
    endtask

    // Walks the program at instruction level: each issue must show the word
    // at the model pc, mvi must be followed by the next word, and the pc
    // advances by 1 or 2 only on done, ending per PROG_LEN/WRAP.
    task automatic runProgram(input int d, input int prog_len, input bit wrap,
                              input int max_instr, input bit random_done, input int stop_pc);
        int pc = 0;
        bit mv;
        logic [8:0] word;
        logic [8:0] held;
        int delay;
        for (int k = 0; k < max_instr; k++) begin
            waitRun(d, 20);
            if (run[d] !== 1'b1) return;
            word = model_mem[d][pc];
            mv = (word[8:6] == OP_MVI);
            checkOutput("issueDin", din[d], word);
            checkOutput("issueAddr", address[d], pc);
            if (random_done && $urandom_range(0, 3) == 0) done[d] = 1'b1;
            tick();
            done[d] = 1'b0;
            held = mv ? model_mem[d][(pc + 1) % 32] : word;
            checkOutput("runOneCycle", run[d], 0);
            checkOutput("noAdvanceFromIssue", address[d], pc);
            checkOutput("wordAfterIssue", din[d], held);
            if (pc == stop_pc) return;
            delay = random_done ? int'($urandom_range(0, 3)) : 1;
            for (int j = 0; j < delay; j++) begin
                tick();
                checkOutput("waitRunLow", run[d], 0);
                checkOutput("waitDinHeld", din[d], held);
            end
            applyStimulus(d, 1'b0, 1'b1);
            pc += mv ? 2 : 1;
            if (pc >= prog_len) begin
                if (!wrap) begin
                    checkOutput("haltedAtEnd", halted[d], 1);
                    checkOutput("busyAtEnd", busy[d], 0);
                    checkOutput("haltState", fstate[d], FS_HALT);
                    return;
                end
                pc = 0;
            end
            checkOutput("pcAfterDone", address[d], pc);
            checkOutput("stateAfterDone", fstate[d], AFTER_DONE_STATE);
        end
    endtask

    // Linear sequence of directed and randomized steps.
    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst       = 1'b0;
        start     = '0;
        prog_we   = '0;
        done      = '0;
        prog_addr = '0;
        prog_data = '0;
`ifdef IFU_SINGLE_STEP_EN
        step      = '1;
`endif
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput("rstRun", run[d], 0);
            checkOutput("rstDin", din[d], 0);
            checkOutput("rstAddr", address[d], 0);
            checkOutput("rstBusy", busy[d], 0);
            checkOutput("rstHalted", halted[d], 0);
            checkOutput("rstState", fstate[d], FS_IDLE);
        end
        rst = 1'b1;
        tick();

        // Short mvi / add program with exact issue timing.
        loadWord(0, 5'd0, 9'h040, 1'b1);
        loadWord(0, 5'd1, 9'h005, 1'b1);
        loadWord(0, 5'd2, 9'h080, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("t1FetchState", fstate[0], FS_FETCH);
        checkOutput("t1FetchBusy", busy[0], 1);
        checkOutput("t1FetchRun", run[0], 0);
        tick();
        checkOutput("t1IssueRun", run[0], 1);
        checkOutput("t1IssueDin", din[0], 9'h040);
        checkOutput("t1IssueAddr", address[0], 0);
        tick();
        checkOutput("t1ImmDin", din[0], 9'h005);
        checkOutput("t1ImmRun", run[0], 0);
        checkOutput("t1ImmState", fstate[0], FS_IMM);
        tick();
        checkOutput("t1WaitState", fstate[0], FS_WAIT);
        checkOutput("t1WaitDin", din[0], 9'h005);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("t1AfterDoneState", fstate[0], AFTER_DONE_STATE);
        waitRun(0, 10);
        checkOutput("t1AddDin", din[0], 9'h080);
        checkOutput("t1AddAddr", address[0], 2);

        // Long wait for done, then a single advance to HALT.
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("t2HoldDin", din[0], 9'h080);
            checkOutput("t2HoldRun", run[0], 0);
            checkOutput("t2HoldAddr", address[0], 2);
            tick();
        end
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("t2Halted", halted[0], 1);
        checkOutput("t2Busy", busy[0], 0);
        checkOutput("t2State", fstate[0], FS_HALT);
        tick();
        checkOutput("t2NoRunInHalt", run[0], 0);

        // Writes while busy are dropped; writes in HALT land.
        applyStimulus(0, 1'b1, 1'b0);
        loadWord(0, 5'd2, 9'h0C0, 1'b0);
        runProgram(0, 3, 1'b0, 10, 1'b1, -1);
        loadWord(0, 5'd2, 9'h0C0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        runProgram(0, 3, 1'b0, 10, 1'b1, -1);

`ifdef IFU_SINGLE_STEP_EN
        // Single-step: park in PAUSE until step is given.
        step[0] = 1'b0;
        applyStimulus(0, 1'b1, 1'b0);
        waitRun(0, 10);
        tick();
        applyStimulus(0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t6PauseState", fstate[0], FS_PAUSE);
            checkOutput("t6PauseRun", run[0], 0);
            checkOutput("t6PauseBusy", busy[0], 1);
            tick();
        end
        step[0] = 1'b1;
        tick();
        checkOutput("t6StepFetch", fstate[0], FS_FETCH);
        tick();
        checkOutput("t6StepRun", run[0], 1);
        checkOutput("t6StepDin", din[0], 9'h0C0);
        tick();
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("t6Halted", halted[0], 1);
`endif

        // Random 32-word programs: wrapping and halting at the end.
        loadRandomProgram(1);
        loadWord(1, 5'd30, 9'h09A, 1'b1);
        loadWord(1, 5'd31, 9'h000, 1'b1);
        loadRandomProgram(2);
        loadWord(2, 5'd6, 9'h0C1, 1'b1);
        loadWord(2, 5'd7, 9'h012, 1'b1);
        loadWord(2, 5'd30, 9'h089, 1'b1);
        loadWord(2, 5'd31, 9'h07F, 1'b1);
        applyStimulus(1, 1'b1, 1'b0);
        runProgram(1, 32, 1'b1, 60, 1'b1, -1);
        applyStimulus(2, 1'b1, 1'b0);
        runProgram(2, 32, 1'b0, 100, 1'b1, -1);

        // Reset while waiting at pc 7, then rerun from the intact store.
        applyStimulus(2, 1'b1, 1'b0);
        runProgram(2, 32, 1'b0, 100, 1'b0, 7);
        checkOutput("t4WaitAddr", address[2], 7);
        rst = 1'b0;
        #1;
        checkOutput("t4RstRun", run[2], 0);
        checkOutput("t4RstDin", din[2], 0);
        checkOutput("t4RstAddr", address[2], 0);
        checkOutput("t4RstState", fstate[2], FS_IDLE);
        checkOutput("t4RstBusy", busy[2], 0);
        checkOutput("t4RstWrapUnit", fstate[1], FS_IDLE);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checkOutput("t4IdleAfterRst", busy[2], 0);
        applyStimulus(2, 1'b1, 1'b0);
        runProgram(2, 32, 1'b0, 100, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
